sub_a_ctrl: RTL and testbench
=============================

Name: sub_a_ctrl

Overview:
- Sequencer and arbiter that shares one sub_a instance between two requesters.
- Accepts an operand set from a requester and drives sub_a's inputs.
- Waits a programmable settle time, then captures sub_a's three outputs and returns them to the winning requester over a valid/ready response channel.
- Sits beside sub_a in the parent; all sub_a inputs except floating_input come from this block.

Parameters:
- SETTLE_CYCLES, 2, cycles sub_a inputs are held before capture; 0 behaves as 1.
- CNT_W, 4, width of settle/timeout counter; SETTLE_CYCLES and RSP_TIMEOUT must be < 2**CNT_W.
- RSP_TIMEOUT, 15, response timeout in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 has an operand set
- req0_data  input  6  {bus_in[2:0], testi3, testi2, testi1} for requester 0
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid  input  1  requester 1 has an operand set
- req1_data  input  6  same layout as req0_data
- req1_ready  output  1  requester 1 accepted this cycle
- rsp0_valid  output  1  result available for requester 0
- rsp0_ready  input  1  requester 0 takes result
- rsp1_valid  output  1  result available for requester 1
- rsp1_ready  input  1  requester 1 takes result
- rsp_data  output  3  {testo1_sub_a, testo2_a, testo1_a}, shared by both requesters
- sa_testi1_a  output  1  to sub_a testi1_a
- sa_testi2_a  output  1  to sub_a testi2_a
- sa_testi3_a  output  1  to sub_a testi3_a
- sa_bus_in  output  3  to sub_a bus_in
- sa_zero_tied  output  1  to sub_a zero_tied, constant 0
- sa_reset_n  output  1  to sub_a reset_n, registered ~reset
- sa_testo1_a  input  1  from sub_a
- sa_testo2_a  input  1  from sub_a
- sa_testo1_sub_a  input  1  from sub_a
- busy  output  1  state != IDLE
- grant_id  output  1  requester currently owning sub_a
- timeout_err  output  1  one-cycle pulse on response timeout

Behaviour:
- Reset values: all outputs 0 except sa_reset_n, which is 0 during reset and 1 on the first cycle after reset deasserts. Round-robin pointer favours req0 after reset.
- States and transitions:
  - IDLE: state after reset.
  - IDLE -> SETTLE: when any reqN_valid is high.
  - SETTLE -> RESP: when the settle count expires.
  - RESP -> IDLE: when rspN_ready is high for the granted requester.
- Arbitration in IDLE:
  - With only one requester valid, that requester wins.
  - With both valid, the requester favoured by the pointer wins.
  - reqN_ready is combinational (IDLE & winner), so it is asserted in the same cycle as reqN_valid. The handshake completes on that edge.
- Accept edge:
  - req data is registered into sa_* outputs.
  - grant_id is set to the winner.
  - Counter loads max(SETTLE_CYCLES,1).
  - Pointer moves to favour the other requester.
- SETTLE:
  - sa_* outputs are held stable.
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, {sa_testo1_sub_a, sa_testo2_a, sa_testo1_a} is sampled into rsp_data and the block moves to RESP.
- Latency: handshake at the edge ending cycle T gives rspN_valid high from cycle T+1+max(SETTLE_CYCLES,1).
- RESP:
  - rspN_valid is high only for grant_id.
  - rsp_data and sa_* outputs are held.
  - On the rspN_ready & rspN_valid edge, rspN_valid drops, sa_testi*/sa_bus_in clear to 0, and the block returns to IDLE.
  - A new request can be accepted on the first IDLE cycle: one idle cycle minimum between jobs.
- reqN_valid is ignored outside IDLE. A requester holding valid keeps waiting.
- rsp_ready from the non-granted requester is ignored.
- rsp_data retains its last value in IDLE.
- Reset asserted in any state aborts the job on the next edge and returns all outputs to reset values. No response is issued for the aborted job.

Optional Feature:
- Macro SUB_A_CTRL_RSP_TIMEOUT_EN.
- Defined:
  - On entry to RESP the counter loads RSP_TIMEOUT and decrements while rspN_ready is low.
  - If it reaches 0 without a handshake, timeout_err pulses for 1 cycle, rspN_valid drops, sa_* clear, and the block returns to IDLE.
  - A handshake on the same cycle the counter reaches 0 wins, with no timeout_err.
- Undefined: RESP waits indefinitely and timeout_err is tied 0. The port list is identical in both builds.

Test Plan:
- Single request: reset, then req0_valid=1, req0_data=6'b001_011, rsp0_ready=1. Required response: req0_ready in the same cycle; sa_testi1/2/3=1/1/0 and sa_bus_in=3'b001 next cycle; rsp0_valid 3 cycles after accept; rsp_data[1:0]=2'b10 per the sub_a model; rsp1_valid stays 0.
- Contention: req0_valid and req1_valid held at 1 for 4 jobs, both rsp_ready=1. Required response: grant order 0,1,0,1; each accept is preceded by one IDLE cycle.
- Backpressure: hold rsp1_ready=0 for 10 cycles after rsp1_valid. Required response: rsp1_valid, rsp_data and sa_* are stable throughout; the handshake on cycle 11 returns the block to IDLE; busy=0 next cycle.
- Reset mid-job: assert reset during SETTLE. Required response: busy, grant_id, rsp*_valid and sa_* are 0 next cycle; sa_reset_n=0; after release, the next req0 is granted first.
- SETTLE_CYCLES=0 build: run a single request. Required response: rsp valid 2 cycles after accept, identical to SETTLE_CYCLES=1.
- Timeout (macro defined, RSP_TIMEOUT=4): rsp0_ready held 0. Required response: timeout_err pulses once on the 4th RESP cycle, then IDLE. Repeat with rsp0_ready=1 exactly on that cycle: no timeout_err and a normal handshake.

Source files
------------

// File: rtl/sub_a_ctrl.sv
// Sequencer/arbiter sharing one sub_a between two requesters: accept, settle, capture, respond.
// Optional response timeout is enabled by defining SUB_A_CTRL_RSP_TIMEOUT_EN.
module sub_a_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4,
    parameter int RSP_TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [5:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [5:0] req1_data,
    output logic       req1_ready,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [2:0] rsp_data,
    output logic       sa_testi1_a,
    output logic       sa_testi2_a,
    output logic       sa_testi3_a,
    output logic [2:0] sa_bus_in,
    output logic       sa_zero_tied,
    output logic       sa_reset_n,
    input  logic       sa_testo1_a,
    input  logic       sa_testo2_a,
    input  logic       sa_testo1_sub_a,
    output logic       busy,
    output logic       grant_id,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // A settle time of 0 would skip the capture point, so it is treated as 1.
    localparam int              SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_EFF);
    localparam logic [CNT_W-1:0] RSP_LOAD    = CNT_W'(RSP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ptr;
    logic             any_req;
    logic             win_id;
    logic             accept_ok;
    logic             rsp_take;

    always_comb begin
        any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            win_id = ptr;
        end else begin
            win_id = req1_valid;
        end
    end

    assign accept_ok  = (state == IDLE) & ~reset & any_req;
    assign req0_ready = accept_ok & ~win_id;
    assign req1_ready = accept_ok & win_id;
    assign rsp_take   = grant_id ? rsp1_ready : rsp0_ready;

    assign busy         = (state != IDLE);
    assign sa_zero_tied = 1'b0;

    always_ff @(posedge clk) begin
        sa_reset_n <= ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= 1'b0;
            grant_id    <= 1'b0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp_data    <= '0;
            sa_testi1_a <= 1'b0;
            sa_testi2_a <= 1'b0;
            sa_testi3_a <= 1'b0;
            sa_bus_in   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        {sa_bus_in, sa_testi3_a, sa_testi2_a, sa_testi1_a} <=
                            win_id ? req1_data : req0_data;
                        grant_id <= win_id;
                        ptr      <= ~win_id;
                        cnt      <= SETTLE_LOAD;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt <= CNT_ONE) begin
                        rsp_data   <= {sa_testo1_sub_a, sa_testo2_a, sa_testo1_a};
                        rsp0_valid <= ~grant_id;
                        rsp1_valid <= grant_id;
                        cnt        <= RSP_LOAD;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        {sa_bus_in, sa_testi3_a, sa_testi2_a, sa_testi1_a} <= '0;
                        state      <= IDLE;
                    end
`ifdef SUB_A_CTRL_RSP_TIMEOUT_EN
                    // A handshake on the final count takes priority over the timeout.
                    else if (cnt <= CNT_ONE) begin
                        timeout_err <= 1'b1;
                        rsp0_valid  <= 1'b0;
                        rsp1_valid  <= 1'b0;
                        {sa_bus_in, sa_testi3_a, sa_testi2_a, sa_testi1_a} <= '0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_a_ctrl.sv
// Directed bench for sub_a_ctrl with a tiny sub_a stand-in model; second instance covers SETTLE_CYCLES=0.
`timescale 1ns/1ps
module tb_sub_a_ctrl;

    localparam int SET_EFF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [5:0] req0_data, req1_data;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [2:0] rsp_data;
    logic       sa_testi1_a, sa_testi2_a, sa_testi3_a, sa_zero_tied, sa_reset_n;
    logic [2:0] sa_bus_in;
    logic       sa_testo1_a, sa_testo2_a, sa_testo1_sub_a;
    logic       busy, grant_id, timeout_err;

    logic       z_req0_valid, z_req1_valid, z_req0_ready, z_req1_ready;
    logic [5:0] z_req0_data, z_req1_data;
    logic       z_rsp0_valid, z_rsp1_valid, z_rsp0_ready, z_rsp1_ready;
    logic [2:0] z_rsp_data;
    logic       z_testi1, z_testi2, z_testi3, z_zero_tied, z_reset_n;
    logic [2:0] z_bus_in;
    logic       z_testo1, z_testo2, z_testo1_sub;
    logic       z_busy, z_grant_id, z_timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // sub_a stand-in: testo1_a = t1&t3, testo2_a = t1|t2, testo1_sub_a = ^bus_in
    assign sa_testo1_a     = sa_testi1_a & sa_testi3_a;
    assign sa_testo2_a     = sa_testi1_a | sa_testi2_a;
    assign sa_testo1_sub_a = ^sa_bus_in;
    assign z_testo1        = z_testi1 & z_testi3;
    assign z_testo2        = z_testi1 | z_testi2;
    assign z_testo1_sub    = ^z_bus_in;

    sub_a_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4), .RSP_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data),
        .sa_testi1_a(sa_testi1_a), .sa_testi2_a(sa_testi2_a), .sa_testi3_a(sa_testi3_a),
        .sa_bus_in(sa_bus_in), .sa_zero_tied(sa_zero_tied), .sa_reset_n(sa_reset_n),
        .sa_testo1_a(sa_testo1_a), .sa_testo2_a(sa_testo2_a), .sa_testo1_sub_a(sa_testo1_sub_a),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    sub_a_ctrl #(.SETTLE_CYCLES(0), .CNT_W(4), .RSP_TIMEOUT(15)) dut_s0 (
        .clk(clk), .reset(reset),
        .req0_valid(z_req0_valid), .req0_data(z_req0_data), .req0_ready(z_req0_ready),
        .req1_valid(z_req1_valid), .req1_data(z_req1_data), .req1_ready(z_req1_ready),
        .rsp0_valid(z_rsp0_valid), .rsp0_ready(z_rsp0_ready),
        .rsp1_valid(z_rsp1_valid), .rsp1_ready(z_rsp1_ready),
        .rsp_data(z_rsp_data),
        .sa_testi1_a(z_testi1), .sa_testi2_a(z_testi2), .sa_testi3_a(z_testi3),
        .sa_bus_in(z_bus_in), .sa_zero_tied(z_zero_tied), .sa_reset_n(z_reset_n),
        .sa_testo1_a(z_testo1), .sa_testo2_a(z_testo2), .sa_testo1_sub_a(z_testo1_sub),
        .busy(z_busy), .grant_id(z_grant_id), .timeout_err(z_timeout_err)
    );

    typedef struct {
        logic       id;
        logic [5:0] data;
        logic [2:0] exp_rsp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input logic id, input logic [5:0] d, input logic [2:0] e);
        int lat;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        chk("req_ready", {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        chk("idle_at_accept", busy, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("busy_settle", busy, 1'b1);
        chk("grant_id", grant_id, id);
        chk("sa_inputs", {sa_bus_in, sa_testi3_a, sa_testi2_a, sa_testi1_a}, d);
        chk("zero_tied", sa_zero_tied, 1'b0);
        lat = 0;
        while (!(rsp0_valid | rsp1_valid) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, SET_EFF);
        chk("rsp_valid", {rsp1_valid, rsp0_valid}, id ? 2'b10 : 2'b01);
        chk("rsp_data", rsp_data, e);
        @(negedge clk);
        chk("idle_after", {busy, rsp1_valid, rsp0_valid}, 3'b000);
        chk("sa_cleared", {sa_bus_in, sa_testi3_a, sa_testi2_a, sa_testi1_a}, 6'b0);
        chk("rsp_data_kept", rsp_data, e);
    endtask

    vec_t vecs[5];

    initial begin
        int lat, cyc, last, waited;

        vecs[0] = '{id: 1'b0, data: 6'b001_011, exp_rsp: 3'b110};
        vecs[1] = '{id: 1'b1, data: 6'b110_101, exp_rsp: 3'b011};
        vecs[2] = '{id: 1'b0, data: 6'b111_100, exp_rsp: 3'b100};
        vecs[3] = '{id: 1'b1, data: 6'b000_000, exp_rsp: 3'b000};
        vecs[4] = '{id: 1'b1, data: 6'b010_111, exp_rsp: 3'b111};

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        z_req0_valid = 1'b0; z_req1_valid = 1'b0; z_req0_data = '0; z_req1_data = '0;
        z_rsp0_ready = 1'b0; z_rsp1_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy_grant", {busy, grant_id, timeout_err}, 3'b000);
        chk("rst_rsp", {rsp1_valid, rsp0_valid, rsp_data}, 5'b0);
        chk("rst_sa", {sa_bus_in, sa_testi3_a, sa_testi2_a, sa_testi1_a}, 6'b0);
        chk("rst_sa_reset_n", sa_reset_n, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("sa_reset_n_release", sa_reset_n, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].id, vecs[i].data, vecs[i].exp_rsp);
        end

        // Reset during SETTLE, then contention must start with requester 0.
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 6'b101_101;
        @(negedge clk);
        req0_valid = 1'b0;
        chk("mid_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctrl", {busy, grant_id, rsp1_valid, rsp0_valid}, 4'b0);
        chk("mid_rst_sa", {sa_bus_in, sa_testi3_a, sa_testi2_a, sa_testi1_a}, 6'b0);
        chk("mid_rst_sa_reset_n", sa_reset_n, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_release", {sa_reset_n, busy, rsp1_valid, rsp0_valid}, 4'b1000);

        req0_valid = 1'b1; req0_data = 6'b011_000;
        req1_valid = 1'b1; req1_data = 6'b100_111;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        cyc = 0;
        last = 0;
        for (int j = 0; j < 4; j++) begin
            waited = 0;
            while (!(req0_ready | req1_ready) && waited < 20) begin
                @(negedge clk);
                cyc++;
                waited++;
            end
            chk("cont_onehot", req0_ready ^ req1_ready, 1'b1);
            chk("cont_winner", req1_ready, j % 2);
            chk("cont_idle", busy, 1'b0);
            if (j > 0) chk("cont_gap", cyc - last, SET_EFF + 2);
            last = cyc;
            @(negedge clk);
            cyc++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (SET_EFF + 3) @(negedge clk);
        chk("cont_done", {busy, rsp1_valid, rsp0_valid}, 3'b000);

`ifndef SUB_A_CTRL_RSP_TIMEOUT_EN
        // Backpressure on requester 1; requester 0's ready must be ignored.
        req1_valid = 1'b1; req1_data = 6'b101_010;
        rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        lat = 0;
        while (!rsp1_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, SET_EFF);
        for (int k = 1; k <= 11; k++) begin
            chk("bp_hold", {rsp1_valid, rsp0_valid, rsp_data, sa_bus_in, sa_testi3_a, sa_testi2_a, sa_testi1_a},
                {2'b10, 3'b010, 6'b101_010});
            if (k == 11) rsp1_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp_release", {busy, rsp1_valid}, 2'b00);
        chk("bp_timeout_tied", timeout_err, 1'b0);
`else
        // Timeout with ready held low, then a handshake on the final count.
        for (int r = 0; r < 2; r++) begin
            req0_valid = 1'b1; req0_data = 6'b001_011;
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
            @(negedge clk);
            req0_valid = 1'b0;
            lat = 0;
            while (!rsp0_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("to_latency", lat, SET_EFF);
            repeat (3) @(negedge clk);
            chk("to_4th_cycle", {rsp0_valid, timeout_err}, 2'b10);
            if (r == 1) rsp0_ready = 1'b1;
            @(negedge clk);
            chk("to_outcome", {timeout_err, busy, rsp0_valid}, (r == 0) ? 3'b100 : 3'b000);
            chk("to_sa_clear", {sa_bus_in, sa_testi3_a, sa_testi2_a, sa_testi1_a}, 6'b0);
            @(negedge clk);
            chk("to_pulse_end", timeout_err, 1'b0);
        end
        rsp0_ready = 1'b0;
`endif

        // SETTLE_CYCLES=0 instance must behave as SETTLE_CYCLES=1.
        @(negedge clk);
        z_req0_valid = 1'b1; z_req0_data = 6'b011_001; z_rsp0_ready = 1'b1;
        #1;
        chk("s0_ready", z_req0_ready, 1'b1);
        @(negedge clk);
        z_req0_valid = 1'b0;
        lat = 0;
        while (!z_rsp0_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("s0_latency", lat, 1);
        chk("s0_rsp_data", z_rsp_data, 3'b010);
        @(negedge clk);
        chk("s0_idle", {z_busy, z_rsp0_valid, z_rsp1_valid}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
